// File: rtl/timer_int_ctrl.sv
// ============================================================================
//  Module   : timer_int_ctrl
//  Brief    : Programmable timer and interrupt source for the fetch-stage
//             redirect interface (INT_detected / INT_restore).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module timer_int_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'h00007F00,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        int_ok,
  input  logic        eret,
  output logic        INT_detected,
  output logic        INT_restore,
  output logic        irq_pending
);

  localparam logic [1:0] C_SEL_CTRL   = 2'd0;
  localparam logic [1:0] C_SEL_PRESET = 2'd1;
  localparam logic [1:0] C_SEL_COUNT  = 2'd2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_en;
  logic             r_mode;
  logic             r_im;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic             r_pending;
  logic             r_int_detected;
  logic             r_int_restore;

  logic       w_hit;
  logic [1:0] w_sel;
  logic       w_wr_ctrl;
  logic       w_wr_preset;
  logic       w_expiry;

  assign w_hit       = (addr[31:4] == ADDR_BASE[31:4]);
  assign w_sel       = addr[3:2];
  assign w_wr_ctrl   = we && w_hit && (w_sel == C_SEL_CTRL);
  assign w_wr_preset = we && w_hit && (w_sel == C_SEL_PRESET);
  // A PRESET write reloads COUNT, so it also suppresses the 1->0 expiry.
  assign w_expiry    = r_en && !w_wr_preset && (r_count == CNT_W'(1));

  always_comb begin
    rdata = '0;
    if (w_hit) begin
      case (w_sel)
        C_SEL_CTRL:   rdata = {28'd0, r_im, 1'b0, r_mode, r_en};
        C_SEL_PRESET: rdata = 32'(r_preset);
        C_SEL_COUNT:  rdata = 32'(r_count);
        default:      rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en     <= 1'b0;
      r_mode   <= 1'b0;
      r_im     <= 1'b0;
      r_preset <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_preset) begin
        r_preset <= wdata[CNT_W-1:0];
        r_count  <= wdata[CNT_W-1:0];
      end else if (r_en) begin
        if (r_count == '0) begin
          if (r_mode) r_count <= r_preset;
        end else begin
          r_count <= r_count - CNT_W'(1);
        end
      end

      if (w_wr_ctrl) begin
        r_en   <= wdata[0];
        r_mode <= wdata[1];
        r_im   <= wdata[3];
      end else if (w_expiry && !r_mode) begin
        r_en <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_pending      <= 1'b0;
      r_int_detected <= 1'b0;
      r_int_restore  <= 1'b0;
    end else begin
      r_int_detected <= 1'b0;
      r_int_restore  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_pending && int_ok) begin
            r_int_detected <= 1'b1;
            r_pending      <= 1'b0;
            r_state        <= SERVICE;
          end
        end
        SERVICE: begin
          if (eret) begin
            r_int_restore <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A fresh expiry wins over a delivery on the same edge.
      if (w_expiry && r_im) r_pending <= 1'b1;
    end
  end

  assign INT_detected = r_int_detected;
  assign INT_restore  = r_int_restore;
  assign irq_pending  = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_timer_int_ctrl.sv
// Scoreboard bench for timer_int_ctrl: a behavioural model predicts each
// cycle's outputs into a queue, a negedge monitor compares against the DUT.
`default_nettype none

module tb_timer_int_ctrl;

  localparam logic [31:0] BASE = 32'h00007F00;

  logic        clk = 1'b0;
  logic        reset, we, int_ok, eret;
  logic [31:0] addr, wdata, rdata;
  logic        INT_detected, INT_restore, irq_pending;

  timer_int_ctrl #(.ADDR_BASE(BASE), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .int_ok       (int_ok),
    .eret         (eret),
    .INT_detected (INT_detected),
    .INT_restore  (INT_restore),
    .irq_pending  (irq_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        det;
    logic        rest;
    logic        pend;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: timer as plain integers, handler tracked as a flag.
  bit          m_en, m_mode, m_im, m_pend, m_in_handler, m_det, m_rest;
  logic [31:0] m_preset, m_count;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_im, 1'b0, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_im = 0; m_pend = 0; m_in_handler = 0;
    m_det = 0; m_rest = 0; m_preset = 0; m_count = 0;
  endtask

  task automatic model_clock();
    bit hit, fires, old_en, old_mode, old_im;
    hit = (addr[31:4] == BASE[31:4]);
    fires = 0; old_en = m_en; old_mode = m_mode; old_im = m_im;
    if (we && hit && addr[3:2] == 2'd1) begin
      m_preset = wdata; m_count = wdata;
    end else if (old_en) begin
      if (m_count == 32'd1) begin fires = 1; m_count = 0; end
      else if (m_count == 32'd0) m_count = old_mode ? m_preset : 32'd0;
      else m_count = m_count - 32'd1;
    end
    if (we && hit && addr[3:2] == 2'd0) begin
      m_en = wdata[0]; m_mode = wdata[1]; m_im = wdata[3];
    end else if (fires && !old_mode) m_en = 0;
    m_det = 0; m_rest = 0;
    if (!m_in_handler && m_pend && int_ok) begin
      m_det = 1; m_pend = 0; m_in_handler = 1;
    end else if (m_in_handler && eret) begin
      m_rest = 1; m_in_handler = 0;
    end
    if (fires && old_im) m_pend = 1;
  endtask

  task automatic step(input bit rst, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input bit ok, input bit er);
    @(posedge clk); #1;
    reset = rst; we = w; addr = a; wdata = d; int_ok = ok; eret = er;
    if (rst) model_reset();
    sb.push_back('{model_read(a), m_det, m_rest, m_pend});
    if (!rst) model_clock();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rdata", rdata, e.rdata);
      check("INT_detected", 32'(INT_detected), 32'(e.det));
      check("INT_restore", 32'(INT_restore), 32'(e.rest));
      check("irq_pending", 32'(irq_pending), 32'(e.pend));
      n_checks++;
      if (INT_detected && INT_restore) begin
        n_fail++;
        $display("FAIL exclusive: INT_detected and INT_restore both 1 at %0t", $time);
      end
    end
  end

  task automatic random_step();
    int k;
    logic [31:0] a, d;
    k = $urandom_range(0, 4);
    if (k < 4) a = BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
    else a = BASE ^ (32'd1 << $urandom_range(4, 31));
    if (k == 1) d = 32'($urandom_range(0, 6));
    else if (k == 0) d = 32'($urandom_range(0, 15));
    else d = $urandom;
    step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 20, a, d,
         $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25);
  endtask

  initial begin
    reset = 1; we = 0; addr = 0; wdata = 0; int_ok = 0; eret = 0;
    model_reset();
    repeat (3) step(1, 0, BASE + 8, 0, 0, 0);

    // Auto-reload, period PRESET+1, handler returns at random.
    step(0, 1, BASE + 4, 32'd5, 1, 0);
    step(0, 1, BASE, 32'hB, 1, 0);
    repeat (30) step(0, 0, BASE + 8, 0, 1, $urandom_range(0, 3) == 0);

    // Reset with registers nonzero, then release.
    repeat (2) step(1, 0, BASE + 8, 0, 1, 1);
    step(0, 0, BASE, 0, 1, 0);

    // One-shot.
    step(0, 1, BASE + 4, 32'd3, 1, 0);
    step(0, 1, BASE, 32'h9, 1, 0);
    repeat (15) step(0, 0, BASE, 0, 1, $urandom_range(0, 2) == 0);
    repeat (2) step(0, 0, BASE + 8, 0, 1, 1);

    // Expiry while int_ok is low.
    step(0, 1, BASE + 4, 32'd2, 0, 0);
    step(0, 1, BASE, 32'h9, 0, 0);
    repeat (8) step(0, 0, BASE + 8, 0, 0, 0);
    repeat (4) step(0, 0, BASE + 8, 0, 1, 0);
    repeat (2) step(0, 0, BASE + 8, 0, 1, 1);

    // Masked expiries, then unmask: nothing may be delivered.
    step(0, 1, BASE + 4, 32'd2, 1, 0);
    step(0, 1, BASE, 32'h3, 1, 0);
    repeat (10) step(0, 0, BASE + 8, 0, 1, 1);
    step(0, 1, BASE, 32'h8, 1, 1);
    repeat (5) step(0, 0, BASE, 0, 1, 1);

    // PRESET = 0 with counting on; COUNT writes ignored.
    step(0, 1, BASE + 4, 32'd0, 1, 0);
    step(0, 1, BASE, 32'hB, 1, 0);
    step(0, 1, BASE + 8, 32'h1234, 1, 0);
    repeat (10) step(0, 0, BASE + 8, 0, 1, 0);

    repeat (4000) random_step();
    repeat (3) step(0, 0, BASE + 8, 0, 1, 1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_int_ctrl.md
Name: timer_int_ctrl

Overview:
Programmable timer and interrupt controller. It is the source end of the fetch-stage interrupt interface: it drives INT_detected and INT_restore into IF. The CPU writes its registers through the data-memory bus. It raises one interrupt pulse per timer expiry and one restore pulse when the handler executes eret.

Parameters:
ADDR_BASE, 32'h00007F00, byte address of the register block (CTRL +0, PRESET +4, COUNT +8)
CNT_W, 32, counter and preset width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
we  input  1  bus write strobe, MEM stage
addr  input  32  bus byte address
wdata  input  32  bus write data
rdata  output  32  register read data, combinational
int_ok  input  1  core can accept redirect this cycle (no stall, no pending branch flush)
eret  input  1  handler return decoded this cycle, one-cycle pulse
INT_detected  output  1  one-cycle pulse: IF saves PC and jumps to handler
INT_restore  output  1  one-cycle pulse: IF reloads saved PC
irq_pending  output  1  an expiry is latched and not yet delivered

Behaviour:
- Register decode: a register is hit when addr[31:4] == ADDR_BASE[31:4]; addr[3:2] selects it. rdata = 0 on a miss or on addr[3:2] = 3.
- CTRL bits:
  - bit0 EN: count enable
  - bit1 MODE: 0 = one-shot, 1 = auto-reload
  - bit3 IM: interrupt mask, 1 = allowed
  - other bits read 0
- PRESET: read/write, CNT_W bits.
- COUNT: read-only; writes are ignored.
- Reset: CTRL = 0, PRESET = 0, COUNT = 0, pending = 0, state = IDLE. INT_detected = INT_restore = irq_pending = 0. Reset asserted mid-service drops to IDLE with no restore pulse.
- A write to PRESET also loads COUNT with wdata in the same edge. That load has priority over decrement and reload.
- Counting, each edge with EN = 1:
  - COUNT > 1: decrement by 1.
  - COUNT = 1: COUNT becomes 0 and an expiry event fires on that edge.
  - COUNT = 0 and MODE = 1: reload COUNT from PRESET. The period is therefore PRESET + 1 cycles; the first expiry after a load comes PRESET cycles later.
  - COUNT = 0 and MODE = 0: hold 0.
- One-shot expiry clears EN on the same edge.
- PRESET = 0: no expiry ever fires.
- Expiry with IM = 1 sets pending. Expiry with IM = 0 is dropped, not latched.
- A second expiry while pending is already set is merged; there is no count of missed expiries.
- irq_pending = pending.
- FSM states: IDLE, SERVICE.
  - IDLE: pending = 1 and int_ok = 1 → INT_detected = 1 for that cycle, clear pending, go to SERVICE. While int_ok = 0, wait in IDLE with pending held.
  - SERVICE: eret = 1 → INT_restore = 1 for that cycle, go to IDLE. No INT_detected is issued in SERVICE (no nesting). An expiry during SERVICE sets pending; delivery comes no earlier than the cycle after INT_restore.
  - eret while in IDLE is ignored.
- INT_detected and INT_restore are registered (Moore) outputs; both high in one cycle is illegal.
- Expiry and delivery on the same edge: pending is set. Delivery happens on the next cycle that satisfies the IDLE rule.
- A write to CTRL that changes IM does not affect an already latched pending.

Test Plan:
- Reset with registers previously nonzero → all outputs 0, rdata at COUNT reads 0. Reset asserted during SERVICE → IDLE, no INT_restore pulse.
- Write PRESET = 5, then CTRL = 0b1011 (EN, auto-reload, IM), int_ok = 1 → COUNT reads 5,4,3,2,1,0,5,…; INT_detected pulses 1 cycle after each 1→0 edge; each eret yields exactly one INT_restore.
- CTRL = 0b1001 (one-shot), PRESET = 3 → one INT_detected, CTRL reads 0b1000 afterwards, COUNT stays 0, no further pulses.
- Expiry with int_ok held 0 for 4 cycles → irq_pending = 1 throughout; INT_detected in the first cycle int_ok = 1.
- Expiry during SERVICE → no INT_detected until eret; INT_restore cycle N, INT_detected at cycle N+1 at earliest; never both high together.
- IM = 0 with expiries occurring, then IM set to 1 → no interrupt from the earlier expiries. Eret in IDLE → no INT_restore. PRESET = 0 with EN = 1 → no interrupt ever.
